// File: rtl/astro_mem_pkg.sv
// Shared definitions for the frame-memory port arbiter.
// Provides requester index constants, the arbiter state enum and the
// per-requester command bundle used to mux onto the memory port.
package astro_mem_pkg;

    localparam int          NUM_REQ = 3;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ID_W    = 2;

    localparam logic [ID_W-1:0] REQ_TEMP = 2'd0;
    localparam logic [ID_W-1:0] REQ_WIND = 2'd1;
    localparam logic [ID_W-1:0] REQ_RES  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        BUSY
    } arb_state_e;

    typedef struct packed {
        logic              rd_wr;
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        logic              tem_win;
    } req_bundle_t;

endpackage

// File: rtl/read_tag_pipe.sv
// Read tag pipe: an RD_LAT-deep shift register of {valid, id} that tracks
// which requester issued each in-flight memory read.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_id       a read beat was issued this cycle, by requester push_id
//   head_valid, head_id entry whose read data is on the memory bus this cycle
//   empty               no read is in flight anywhere in the pipe
module read_tag_pipe
    import astro_mem_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    output logic            head_valid,
    output logic [ID_W-1:0] head_id,
    output logic            empty
);

    logic [RD_LAT-1:0]           valid_q;
    logic [RD_LAT-1:0][ID_W-1:0] id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q[0] <= push;
            id_q[0]    <= push_id;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign head_valid = valid_q[RD_LAT-1];
    assign head_id    = id_q[RD_LAT-1];
    assign empty      = ~|valid_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Frame-memory port arbiter for the template reader (0), window reader (1)
// and NCC result writer (2). Grants one requester at a time with bounded
// bursts, drains in-flight reads before a write turnaround, routes read
// returns to their issuer and counts result writes per frame.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req, rd_wr_in         per-requester request and read(0)/write(1)
//   row_in, col_in        per-requester address
//   tem_win_in            per-requester address-format select
//   wdata_in              write data (requester 2 only)
//   gnt                   one-hot grant
//   rvalid, rdata         one-hot read-return strobe and broadcast data
//   mem_*                 memory-side command / read data
//   frame_done            one-cycle pulse after the last result write of a frame
module mem_port_arbiter
    import astro_mem_pkg::*;
#(
    parameter int unsigned RD_LAT         = 2,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned SETS_PER_FRAME = 150
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         rd_wr_in,
    input  logic [NUM_REQ-1:0][6:0]    row_in,
    input  logic [NUM_REQ-1:0][6:0]    col_in,
    input  logic [NUM_REQ-1:0]         tem_win_in,
    input  logic [DATA_W-1:0]          wdata_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       mem_req,
    output logic                       mem_rd_wr,
    output logic [DATA_W-1:0]          mem_write_data,
    output logic [ADDR_W-1:0]          mem_row,
    output logic [ADDR_W-1:0]          mem_col,
    output logic                       mem_tem_win,
    input  logic [DATA_W-1:0]          mem_read_data,
    output logic                       frame_done
);

    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic              rr_q, rr_d;          // 1: favour window on a 0/1 tie
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              frame_done_q, frame_done_d;

    logic              owner_req;
    logic              beat;
    logic              pipe_push;
    logic              pipe_empty;
    logic              head_valid;
    logic [ID_W-1:0]   head_id;
    logic [ID_W-1:0]   winner;
    req_bundle_t       owner_bundle;

    assign owner_req = req[owner_q];
    assign beat      = (state_q == BUSY) && owner_req;
    assign pipe_push = beat && !owner_bundle.rd_wr;

    always_comb begin
        owner_bundle = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == ID_W'(k)) begin
                owner_bundle.rd_wr   = rd_wr_in[k];
                owner_bundle.row     = row_in[k];
                owner_bundle.col     = col_in[k];
                owner_bundle.tem_win = tem_win_in[k];
            end
        end
    end

    read_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_read_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_push),
        .push_id   (owner_q),
        .head_valid(head_valid),
        .head_id   (head_id),
        .empty     (pipe_empty)
    );

    // Arbitration and burst control
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        beat_cnt_d = beat_cnt_q;
        winner     = owner_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    if (req[REQ_RES]) begin
                        winner = REQ_RES;
                    end else if (req[REQ_TEMP] && req[REQ_WIND]) begin
                        winner = rr_q ? REQ_WIND : REQ_TEMP;
                    end else if (req[REQ_TEMP]) begin
                        winner = REQ_TEMP;
                    end else begin
                        winner = REQ_WIND;
                    end
                    owner_d    = winner;
                    beat_cnt_d = '0;
                    if (winner != REQ_RES) begin
                        rr_d = (winner == REQ_TEMP);
                    end
                    // Write turnaround must wait for outstanding reads to return
                    state_d = (winner == REQ_RES && !pipe_empty) ? DRAIN : BUSY;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end else if (beat_cnt_q == BEAT_W'(MAX_BURST - 1)) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame counter: a pulse frees the count so a same-cycle beat starts the next frame
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        if (beat && owner_q == REQ_RES) begin
            if (frame_cnt_q == 8'(SETS_PER_FRAME - 1)) begin
                frame_cnt_d  = '0;
                frame_done_d = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= REQ_TEMP;
            rr_q         <= 1'b0;
            beat_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Memory command and read-return outputs
    always_comb begin
        gnt            = '0;
        mem_req        = 1'b0;
        mem_rd_wr      = 1'b0;
        mem_write_data = '0;
        mem_row        = '0;
        mem_col        = '0;
        mem_tem_win    = 1'b0;
        if (state_q == BUSY) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                gnt[k] = (owner_q == ID_W'(k));
            end
            mem_req        = owner_req;
            mem_rd_wr      = owner_bundle.rd_wr;
            mem_row        = owner_bundle.row;
            mem_col        = owner_bundle.col;
            mem_tem_win    = owner_bundle.tem_win;
            mem_write_data = (owner_q == REQ_RES) ? wdata_in : '0;
        end
    end

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (head_valid) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                rvalid[k] = (head_id == ID_W'(k));
            end
            rdata = mem_read_data;
        end
    end

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle vector tables for the
// grant/burst behaviour, a read-return scoreboard, and hand sequences for
// frame counting and mid-operation reset.
module tb_mem_port_arbiter;

    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 16;
    localparam int SETS      = 150;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      req = '0;
    logic [2:0]      rd_wr_in = '0;
    logic [2:0][6:0] row_in;
    logic [2:0][6:0] col_in;
    logic [2:0]      tem_win_in = 3'b010;
    logic [31:0]     wdata_in = 32'h1234_5678;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [31:0]     rdata;
    logic            mem_req;
    logic            mem_rd_wr;
    logic [31:0]     mem_write_data;
    logic [6:0]      mem_row;
    logic [6:0]      mem_col;
    logic            mem_tem_win;
    logic [31:0]     mem_read_data;
    logic            frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    mem_port_arbiter #(
        .RD_LAT        (RD_LAT),
        .MAX_BURST     (MAX_BURST),
        .SETS_PER_FRAME(SETS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .rd_wr_in      (rd_wr_in),
        .row_in        (row_in),
        .col_in        (col_in),
        .tem_win_in    (tem_win_in),
        .wdata_in      (wdata_in),
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .mem_req       (mem_req),
        .mem_rd_wr     (mem_rd_wr),
        .mem_write_data(mem_write_data),
        .mem_row       (mem_row),
        .mem_col       (mem_col),
        .mem_tem_win   (mem_tem_win),
        .mem_read_data (mem_read_data),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pattern(int c);
        return 32'hA500_0000 ^ (32'(c) * 32'h0001_0203);
    endfunction

    assign mem_read_data = pattern(cyc);

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Read-return scoreboard: each observed read beat expects a return RD_LAT cycles later
    typedef struct {
        logic [1:0] id;
        int         due;
    } ret_t;
    ret_t sb[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                n_tests++;
                if (rvalid !== (3'b001 << sb[0].id) || rdata !== pattern(cyc)) begin
                    n_fail++;
                    $display("FAIL read_return cyc=%0d: got rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                             cyc, rvalid, rdata, 3'b001 << sb[0].id, pattern(cyc));
                end
                void'(sb.pop_front());
            end else if (rvalid !== 3'b000) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid cyc=%0d: got rvalid=%b, want 000", cyc, rvalid);
            end
            for (int k = 0; k < 3; k++) begin
                if (gnt[k] && req[k] && !rd_wr_in[k]) sb.push_back('{2'(k), cyc + RD_LAT});
            end
        end
    end

    // Per-cycle vector table
    typedef struct {
        logic [2:0] req;
        logic [2:0] rd_wr;
        logic [2:0] gnt;
        logic       mem_req;
        logic       mem_rd_wr;
    } vec_t;
    vec_t vecs[$];

    task automatic add(int n, logic [2:0] r, logic [2:0] rw, logic [2:0] g, logic mr, logic mrw);
        repeat (n) vecs.push_back('{r, rw, g, mr, mrw});
    endtask

    task automatic run_vecs(string name);
        int idx;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            req      = vecs[i].req;
            rd_wr_in = vecs[i].rd_wr;
            @(negedge clk);
            check($sformatf("%s[%0d].gnt", name, i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("%s[%0d].mem_req", name, i), 32'(mem_req), 32'(vecs[i].mem_req));
            if (vecs[i].mem_req)
                check($sformatf("%s[%0d].mem_rd_wr", name, i), 32'(mem_rd_wr),
                      32'(vecs[i].mem_rd_wr));
            if (vecs[i].gnt != 3'b000) begin
                idx = vecs[i].gnt[2] ? 2 : (vecs[i].gnt[1] ? 1 : 0);
                check($sformatf("%s[%0d].mem_row", name, i), 32'(mem_row), 32'(10 + idx));
                check($sformatf("%s[%0d].mem_col", name, i), 32'(mem_col), 32'(20 + idx));
                check($sformatf("%s[%0d].mem_tem_win", name, i), 32'(mem_tem_win),
                      32'(idx == 1));
                if (idx == 2)
                    check($sformatf("%s[%0d].mem_write_data", name, i), mem_write_data,
                          32'h1234_5678);
            end
        end
        vecs.delete();
    endtask

    task automatic check_all_zero(string name);
        check({name, ".gnt"}, 32'(gnt), 32'd0);
        check({name, ".rvalid"}, 32'(rvalid), 32'd0);
        check({name, ".rdata"}, rdata, 32'd0);
        check({name, ".mem_cmd"}, 32'({mem_req, mem_rd_wr, mem_tem_win, mem_row, mem_col}), 32'd0);
        check({name, ".mem_write_data"}, mem_write_data, 32'd0);
        check({name, ".frame_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic do_reset();
        req      = '0;
        rd_wr_in = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            row_in[k] = 7'(10 + k);
            col_in[k] = 7'(20 + k);
        end

        // Single template requester: 16-beat burst, one-cycle bubble, 4 more beats
        do_reset();
        add(1,  3'b001, 3'b000, 3'b000, 1'b0, 1'b0);
        add(16, 3'b001, 3'b000, 3'b001, 1'b1, 1'b0);
        add(1,  3'b001, 3'b000, 3'b000, 1'b0, 1'b0);
        add(4,  3'b001, 3'b000, 3'b001, 1'b1, 1'b0);
        add(1,  3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
        add(3,  3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        run_vecs("single");

        // Template and window both requesting from reset: alternating bursts
        do_reset();
        add(1, 3'b011, 3'b000, 3'b000, 1'b0, 1'b0);
        repeat (2) begin
            add(16, 3'b011, 3'b000, 3'b001, 1'b1, 1'b0);
            add(1,  3'b011, 3'b000, 3'b000, 1'b0, 1'b0);
            add(16, 3'b011, 3'b000, 3'b010, 1'b1, 1'b0);
            add(1,  3'b011, 3'b000, 3'b000, 1'b0, 1'b0);
        end
        add(1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
        add(3, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        run_vecs("round_robin");

        // Window burst, result arrives mid-burst: no preemption, then IDLE, 2x DRAIN, write
        do_reset();
        add(1,  3'b010, 3'b100, 3'b000, 1'b0, 1'b0);
        add(2,  3'b010, 3'b100, 3'b010, 1'b1, 1'b0);
        add(14, 3'b110, 3'b100, 3'b010, 1'b1, 1'b0);
        add(3,  3'b100, 3'b100, 3'b000, 1'b0, 1'b0);
        add(1,  3'b100, 3'b100, 3'b100, 1'b1, 1'b1);
        add(1,  3'b000, 3'b100, 3'b100, 1'b0, 1'b0);
        add(2,  3'b000, 3'b100, 3'b000, 1'b0, 1'b0);
        run_vecs("drain");

        // 300 single-beat result writes: frame_done after the 150th and 300th
        do_reset();
        for (int w = 1; w <= 2 * SETS; w++) begin
            @(posedge clk);
            #1;
            req      = 3'b100;
            rd_wr_in = 3'b100;
            wdata_in = 32'hD000_0000 + 32'(w);
            @(negedge clk);
            check($sformatf("write%0d.idle_gnt", w), 32'(gnt), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("write%0d.gnt", w), 32'(gnt), 32'b100);
            check($sformatf("write%0d.wdata", w), mem_write_data, 32'hD000_0000 + 32'(w));
            check($sformatf("write%0d.no_early_done", w), 32'(frame_done), 32'd0);
            @(posedge clk);
            #1;
            req = 3'b000;
            @(negedge clk);
            check($sformatf("write%0d.frame_done", w), 32'(frame_done), 32'(w % SETS == 0));
        end
        wdata_in = 32'h1234_5678;

        // Reset during a template read burst with two reads pending
        do_reset();
        @(posedge clk);
        #1;
        req      = 3'b011;
        rd_wr_in = 3'b000;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset.gnt", 32'(gnt), 32'b001);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) begin
            @(negedge clk);
            check("in_reset.rvalid", 32'(rvalid), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("post_reset.idle_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        check("post_reset.first_gnt", 32'(gnt), 32'b001);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        req = 3'b000;
        repeat (5) @(negedge clk);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
